energy_monitor: RTL
===================

ENERGY_MONITOR -- requirements
Module: energy_monitor

Interface
REQ-001 SHALL have parameters: BITJ, default 4, weight precision; BITH, default 4, bias precision; DATASPIN, default 256, spin count; SCALING_BIT, default 5, bias-scaling width; LOCAL_ENERGY_BIT, default 16, per-spin energy width.
REQ-002 SHALL have ports (clock and reset first):
 clk_i  in  1  clock;
 rst_ni  in  1  reset, asynchronous, active-low;
 spin_valid_i  in  1  spin vector offered;
 spin_ready_o  out  1  spin vector accepted;
 spin_i  in  DATASPIN  spin vector (1 = +1, 0 = -1);
 hscaling_i  in  SCALING_BIT  bias scale, power of 2, sampled with spin_i;
 weight_valid_i  in  1  weight row offered;
 weight_ready_o  out  1  weight row accepted;
 weight_i  in  DATASPIN*BITJ  row cnt of J;
 hbias_i  in  BITH  signed bias of spin cnt;
 energy_valid_o  out  1  total energy available;
 energy_ready_i  in  1  total energy consumed;
 energy_o  out  ETOT_BIT  signed total energy;
 busy_o  out  1  run in progress.

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-004 IDLE: spin_ready_o=1; on spin handshake SHALL latch spin_i and hscaling_i, clear cnt and accumulator, go RUN.
REQ-005 RUN: weight_ready_o=1; each weight handshake SHALL add the partial energy of spin cnt (rows in order 0..DATASPIN-1) to the accumulator and increment cnt.
REQ-006 Partial energy SHALL be computed from latched spins, weight_i, hbias_i, latched scale, with latched spin bit cnt as current spin.
REQ-007 Accumulation SHALL sign-extend LOCAL_ENERGY_BIT to ETOT_BIT = LOCAL_ENERGY_BIT + clog2(DATASPIN); no saturation needed.
REQ-008 Handshake on row DATASPIN-1 SHALL move to DONE; energy_valid_o SHALL rise the next cycle (macro off).
REQ-009 DONE: energy_valid_o=1, energy_o=accumulator stable until energy_ready_i; handshake SHALL return to IDLE.
REQ-010 spin_ready_o, weight_ready_o, energy_valid_o SHALL be mutually exclusive; busy_o=1 in RUN and DONE.
REQ-011 Weight rows offered outside RUN SHALL be ignored; spin_valid_i outside IDLE SHALL not be accepted.
REQ-012 energy_ready_i high in the cycle DONE is entered SHALL complete in one cycle; spin accepted next cycle earliest.
REQ-013 cnt SHALL be clog2(DATASPIN) bits and never wrap within a run.

Reset
REQ-014 rst_ni low SHALL immediately force IDLE, cnt=0, accumulator=0, energy_o=0, energy_valid_o=0, weight_ready_o=0, busy_o=0, spin_ready_o=1 after release.
REQ-015 Reset mid-run SHALL discard partial sums; the next run SHALL be unaffected.

Configuration
REQ-016 Macro ENERGY_MONITOR_PIPE_EN defined: partial energy SHALL be registered before accumulation; DONE entered one cycle after the last row; energy_valid_o two cycles after last handshake.
REQ-017 Macro undefined: accumulation combinational from the row, latency per REQ-008; results identical either way.

Structure
REQ-018 Shared package SHALL hold the FSM state enum and the ETOT_BIT width function.
REQ-019 SHALL instantiate exactly one partial_energy_calc as sub-module; no other sub-modules.

Verification (DATASPIN=4, BITJ=4, BITH=4)
REQ-020 spin=4'b1111, all J=1, hbias=0, scale=1 -> energy_o=16, valid 1 cycle after 4th row.
REQ-021 spin=4'b0011, all J=1, hbias=0 -> energy_o=0; spin=4'b0000 same rows -> 16.
REQ-022 spin=4'b1111, J=0, hbias=2, scale=4 -> energy_o=32.
REQ-023 weight_valid_i gapped every other cycle and energy_ready_i low 5 cycles -> energy_o held stable, result as REQ-020, no extra rows consumed.
REQ-024 rst_ni pulsed after row 2 -> all outputs at reset values; subsequent REQ-020 run -> 16.
REQ-025 Repeat REQ-020 with ENERGY_MONITOR_PIPE_EN -> 16, valid 2 cycles after last row.

Source files
------------

// File: rtl/energy_monitor_pkg.sv
// Shared types and width helpers for the Ising energy monitor.
package energy_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Total-energy width: one per-spin term widened enough to sum every spin.
    function automatic int etot_bit(input int local_bits, input int spins);
        return local_bits + $clog2(spins);
    endfunction

    function automatic int cnt_bit(input int spins);
        return (spins > 1) ? $clog2(spins) : 1;
    endfunction

endpackage

// File: rtl/energy_monitor_partial_energy_calc.sv
// Per-spin energy term: s_i * (sum_j J_ij * s_j + h_i * scale), spins in {+1,-1}.
module partial_energy_calc
    import energy_monitor_pkg::*;
#(
    parameter int BITJ             = 4,
    parameter int BITH             = 4,
    parameter int DATASPIN         = 256,
    parameter int SCALING_BIT      = 5,
    parameter int LOCAL_ENERGY_BIT = 16
) (
    input  logic [DATASPIN-1:0]         spin_vec,
    input  logic                        spin_cur,
    input  logic [DATASPIN*BITJ-1:0]    weight_row,
    input  logic [BITH-1:0]             hbias,
    input  logic [SCALING_BIT-1:0]      hscaling,
    output logic [LOCAL_ENERGY_BIT-1:0] energy
);

    localparam int LEB = LOCAL_ENERGY_BIT;

    logic [LEB-1:0] field_s;
    logic [LEB-1:0] hbias_ext_s;
    logic [LEB-1:0] scale_ext_s;
    logic [LEB-1:0] bias_s;
    logic [LEB-1:0] sum_s;

    function automatic logic [LEB-1:0] sext_j(input logic [BITJ-1:0] v);
        return {{(LEB-BITJ){v[BITJ-1]}}, v};
    endfunction

    function automatic logic [LEB-1:0] sext_h(input logic [BITH-1:0] v);
        return {{(LEB-BITH){v[BITH-1]}}, v};
    endfunction

    // Local field: add J_ij for +1 neighbours, subtract it for -1 neighbours
    always_comb begin
        field_s = {LEB{1'b0}};
        for (int j = 0; j < DATASPIN; j++) begin
            if (spin_vec[j]) begin
                field_s = field_s + sext_j(weight_row[j*BITJ +: BITJ]);
            end else begin
                field_s = field_s - sext_j(weight_row[j*BITJ +: BITJ]);
            end
        end
    end

    // Bias term and sign of the current spin; modular arithmetic at LEB width
    always_comb begin
        hbias_ext_s = sext_h(hbias);
        scale_ext_s = {{(LEB-SCALING_BIT){1'b0}}, hscaling};
        bias_s      = hbias_ext_s * scale_ext_s;
        sum_s       = field_s + bias_s;
        if (spin_cur) begin
            energy = sum_s;
        end else begin
            energy = {LEB{1'b0}} - sum_s;
        end
    end

endmodule

// File: rtl/energy_monitor.sv
// Streams J rows against a latched spin vector and accumulates the total energy.
// Optional ENERGY_MONITOR_PIPE_EN registers each partial energy before accumulation.
module energy_monitor
    import energy_monitor_pkg::*;
#(
    parameter int  BITJ             = 4,
    parameter int  BITH             = 4,
    parameter int  DATASPIN         = 256,
    parameter int  SCALING_BIT      = 5,
    parameter int  LOCAL_ENERGY_BIT = 16,
    localparam int ETOT_BIT         = etot_bit(LOCAL_ENERGY_BIT, DATASPIN)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     spin_valid_i,
    output logic                     spin_ready_o,
    input  logic [DATASPIN-1:0]      spin_i,
    input  logic [SCALING_BIT-1:0]   hscaling_i,
    input  logic                     weight_valid_i,
    output logic                     weight_ready_o,
    input  logic [DATASPIN*BITJ-1:0] weight_i,
    input  logic [BITH-1:0]          hbias_i,
    output logic                     energy_valid_o,
    input  logic                     energy_ready_i,
    output logic [ETOT_BIT-1:0]      energy_o,
    output logic                     busy_o
);

    localparam int LEB     = LOCAL_ENERGY_BIT;
    localparam int CNT_BIT = cnt_bit(DATASPIN);
    localparam logic [CNT_BIT-1:0] LAST_ROW = CNT_BIT'(DATASPIN - 1);

    state_e               state_r;
    state_e               state_next_s;
    logic [DATASPIN-1:0]  spin_r;
    logic [SCALING_BIT-1:0] hscaling_r;
    logic [CNT_BIT-1:0]   cnt_r;
    logic [ETOT_BIT-1:0]  acc_r;

    logic spin_ready_r, weight_ready_r, energy_valid_r, busy_r;
    logic spin_ready_next_s, weight_ready_next_s, energy_valid_next_s, busy_next_s;

    logic spin_hs_s, weight_hs_s, energy_hs_s, last_hs_s;
    logic acc_en_s, rows_done_s;
    logic [LEB-1:0]      partial_s;
    logic [ETOT_BIT-1:0] addend_s;

    function automatic logic [ETOT_BIT-1:0] sext_e(input logic [LEB-1:0] v);
        return {{(ETOT_BIT-LEB){v[LEB-1]}}, v};
    endfunction

    assign spin_hs_s   = spin_valid_i & spin_ready_r;
    assign weight_hs_s = weight_valid_i & weight_ready_r;
    assign energy_hs_s = energy_valid_r & energy_ready_i;
    assign last_hs_s   = weight_hs_s & (cnt_r == LAST_ROW);

    partial_energy_calc #(
        .BITJ             (BITJ),
        .BITH             (BITH),
        .DATASPIN         (DATASPIN),
        .SCALING_BIT      (SCALING_BIT),
        .LOCAL_ENERGY_BIT (LOCAL_ENERGY_BIT)
    ) u_partial_energy_calc (
        .spin_vec   (spin_r),
        .spin_cur   (spin_r[cnt_r]),
        .weight_row (weight_i),
        .hbias      (hbias_i),
        .hscaling   (hscaling_r),
        .energy     (partial_s)
    );

`ifdef ENERGY_MONITOR_PIPE_EN
    logic [LEB-1:0] pe_r;
    logic           pe_vld_r;
    logic           drain_r;

    // Partial-energy stage; drain_r marks the cycle the last row is being summed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pe_r     <= {LEB{1'b0}};
            pe_vld_r <= 1'b0;
            drain_r  <= 1'b0;
        end else if (spin_hs_s) begin
            pe_r     <= {LEB{1'b0}};
            pe_vld_r <= 1'b0;
            drain_r  <= 1'b0;
        end else begin
            if (weight_hs_s) begin
                pe_r <= partial_s;
            end
            pe_vld_r <= weight_hs_s;
            drain_r  <= last_hs_s;
        end
    end

    assign addend_s    = sext_e(pe_r);
    assign acc_en_s    = pe_vld_r;
    assign rows_done_s = drain_r;
`else
    assign addend_s    = sext_e(partial_s);
    assign acc_en_s    = weight_hs_s;
    assign rows_done_s = last_hs_s;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (spin_hs_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rows_done_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (energy_hs_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the handshake flags come straight from flops
    always_comb begin
        spin_ready_next_s   = 1'b0;
        weight_ready_next_s = 1'b0;
        energy_valid_next_s = 1'b0;
        busy_next_s         = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                spin_ready_next_s = 1'b1;
            end
            ST_RUN: begin
                // Stop offering once the last row is taken (matters while draining)
                weight_ready_next_s = ~last_hs_s;
                busy_next_s         = 1'b1;
            end
            ST_DONE: begin
                energy_valid_next_s = 1'b1;
                busy_next_s         = 1'b1;
            end
            default: begin
                spin_ready_next_s = 1'b1;
            end
        endcase
    end

    // Handshake/status output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spin_ready_r   <= 1'b1;
            weight_ready_r <= 1'b0;
            energy_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            spin_ready_r   <= spin_ready_next_s;
            weight_ready_r <= weight_ready_next_s;
            energy_valid_r <= energy_valid_next_s;
            busy_r         <= busy_next_s;
        end
    end

    // Run context and accumulator; cnt saturates on the last row instead of wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spin_r     <= {DATASPIN{1'b0}};
            hscaling_r <= {SCALING_BIT{1'b0}};
            cnt_r      <= {CNT_BIT{1'b0}};
            acc_r      <= {ETOT_BIT{1'b0}};
        end else if (spin_hs_s) begin
            spin_r     <= spin_i;
            hscaling_r <= hscaling_i;
            cnt_r      <= {CNT_BIT{1'b0}};
            acc_r      <= {ETOT_BIT{1'b0}};
        end else begin
            if (weight_hs_s && (cnt_r != LAST_ROW)) begin
                cnt_r <= cnt_r + {{(CNT_BIT-1){1'b0}}, 1'b1};
            end
            if (acc_en_s) begin
                acc_r <= acc_r + addend_s;
            end
        end
    end

    assign spin_ready_o   = spin_ready_r;
    assign weight_ready_o = weight_ready_r;
    assign energy_valid_o = energy_valid_r;
    assign busy_o         = busy_r;
    assign energy_o       = acc_r;

endmodule
